// File: rtl/dtcfg_scheduler_pkg.sv
// Shared PWM types for the dead-time configuration scheduler and its state encoding.
// `DTCOUNT_WIDTH sets the dead-time counter width used across the bank.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

package PKG_pwm;

  typedef enum logic { PWM_OFF = 1'b0, PWM_ON = 1'b1 } _pwm_onoff;
  typedef enum logic { DT_OFF  = 1'b0, DT_ON  = 1'b1 } _dt_onoff;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_PEND  = 3'd2,
    S_APPLY = 3'd3,
    S_FAULT = 3'd4
  } _state_dtcfg;

endpackage

// File: rtl/dtcfg_scheduler_if.sv
// Register-side update channel: request fields plus the one-cycle acknowledge.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

interface dtcfg_scheduler_if
  import PKG_pwm::*;
#(
  parameter int unsigned CH_W = 3
);
  logic                      cfg_req;
  logic [CH_W-1:0]           cfg_chan;
  logic [`DTCOUNT_WIDTH-1:0] cfg_dtime;
  logic                      cfg_logic;
  _dt_onoff                  cfg_dt_onoff;
  logic                      cfg_ack;

  modport master (
    output cfg_req, cfg_chan, cfg_dtime, cfg_logic, cfg_dt_onoff,
    input  cfg_ack
  );

  modport slave (
    input  cfg_req, cfg_chan, cfg_dtime, cfg_logic, cfg_dt_onoff,
    output cfg_ack
  );
endinterface

// File: rtl/dtcfg_scheduler_shadow_bank.sv
// Live per-channel dead-time configuration with a single write port.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

module dtcfg_shadow_bank #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned CH_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [CH_W-1:0]                wr_chan,
  input  logic [`DTCOUNT_WIDTH-1:0]      wr_dtime,
  input  logic                           wr_logic,
  input  logic                           wr_dt_onoff,
  output logic [N_CH*`DTCOUNT_WIDTH-1:0] dtime_out,
  output logic [N_CH-1:0]                logic_out,
  output logic [N_CH-1:0]                dt_onoff_out
);
  localparam int unsigned DW = `DTCOUNT_WIDTH;

  // Reset polarity is all-ones with dead-time enabled (DT_ON encodes as 1).
  always_ff @(posedge clk) begin
    if (reset) begin
      dtime_out    <= '0;
      logic_out    <= '1;
      dt_onoff_out <= '1;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_chan == CH_W'(i)) begin
          dtime_out[i*DW +: DW] <= wr_dtime;
          logic_out[i]          <= wr_logic;
          dt_onoff_out[i]       <= wr_dt_onoff;
        end
      end
    end
  end
endmodule

// File: rtl/dtcfg_scheduler.sv
// Dead-time configuration scheduler: shadows updates and commits them at a safe sync point.
// Optional DTCFG_SYNC_TIMEOUT_EN drops an update after MAX_SYNC unusable sync ticks.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

module dtcfg_scheduler
  import PKG_pwm::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned MAX_SYNC = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  dtcfg_scheduler_if.slave               cfg,
  input  logic                           sync_tick,
  input  logic [N_CH-1:0]                pwmin,
  input  logic                           fault,
  input  logic                           fault_clr,
  output logic [N_CH*`DTCOUNT_WIDTH-1:0] dtime_out,
  output logic [N_CH-1:0]                logic_out,
  output logic [N_CH-1:0]                dt_onoff_out,
  output _pwm_onoff                      pwm_onoff,
  output logic                           busy,
  output logic                           upd_done,
  output logic                           upd_drop
);
  localparam int unsigned CNT_W = $clog2(MAX_SYNC + 1);

  _state_dtcfg state, state_d;
  _pwm_onoff   pwm_d;
  logic        ack_d, busy_d, done_d, sh_ld, bank_we, use_cfg;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [CH_W-1:0]           sh_chan;
  logic [`DTCOUNT_WIDTH-1:0] sh_dtime;
  logic                      sh_logic;
  _dt_onoff                  sh_dt_onoff;

  logic req_new, chan_ok, pend_pwm;

  // A request still high while its ack is showing is the one just taken.
  assign req_new = cfg.cfg_req && !cfg.cfg_ack;
  assign chan_ok = 32'(cfg.cfg_chan) < N_CH;

  always_comb begin
    pend_pwm = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (sh_chan == CH_W'(i)) pend_pwm = pwmin[i];
  end

`ifdef DTCFG_SYNC_TIMEOUT_EN
  logic drop_d;
`endif

  always_comb begin
    state_d = state;
    pwm_d   = pwm_onoff;
    ack_d   = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = cnt;
    sh_ld   = 1'b0;
    bank_we = 1'b0;
    use_cfg = 1'b0;
`ifdef DTCFG_SYNC_TIMEOUT_EN
    drop_d  = 1'b0;
`endif
    if (fault) begin
      state_d = S_FAULT;
      pwm_d   = PWM_OFF;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (req_new) begin
            ack_d   = 1'b1;
            bank_we = chan_ok;
            use_cfg = 1'b1;
          end
          if (sync_tick) begin
            state_d = S_IDLE;
            pwm_d   = PWM_ON;
          end
        end
        S_IDLE: begin
          if (req_new) begin
            ack_d = 1'b1;
            if (chan_ok) begin
              sh_ld   = 1'b1;
              busy_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (sync_tick) begin
            if (!pend_pwm) begin
              state_d = S_APPLY;
`ifdef DTCFG_SYNC_TIMEOUT_EN
            end else if (32'(cnt) + 1 >= MAX_SYNC) begin
              drop_d  = 1'b1;
              busy_d  = 1'b0;
              cnt_d   = '0;
              state_d = S_IDLE;
`endif
            end else if (32'(cnt) < MAX_SYNC) begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        S_APPLY: begin
          bank_we = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) state_d = S_OFF;
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_OFF;
      pwm_onoff   <= PWM_OFF;
      cfg.cfg_ack <= 1'b0;
      busy        <= 1'b0;
      upd_done    <= 1'b0;
      cnt         <= '0;
      sh_chan     <= '0;
      sh_dtime    <= '0;
      sh_logic    <= 1'b0;
      sh_dt_onoff <= DT_OFF;
    end else begin
      state       <= state_d;
      pwm_onoff   <= pwm_d;
      cfg.cfg_ack <= ack_d;
      busy        <= busy_d;
      upd_done    <= done_d;
      cnt         <= cnt_d;
      if (sh_ld) begin
        sh_chan     <= cfg.cfg_chan;
        sh_dtime    <= cfg.cfg_dtime;
        sh_logic    <= cfg.cfg_logic;
        sh_dt_onoff <= cfg.cfg_dt_onoff;
      end
    end
  end

`ifdef DTCFG_SYNC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) upd_drop <= 1'b0;
    else       upd_drop <= drop_d;
  end
`else
  assign upd_drop = 1'b0;
`endif

  // While off nothing is switching, so requests bypass the shadow.
  dtcfg_shadow_bank #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (bank_we),
    .wr_chan      (use_cfg ? cfg.cfg_chan : sh_chan),
    .wr_dtime     (use_cfg ? cfg.cfg_dtime : sh_dtime),
    .wr_logic     (use_cfg ? cfg.cfg_logic : sh_logic),
    .wr_dt_onoff  (use_cfg ? (cfg.cfg_dt_onoff == DT_ON) : (sh_dt_onoff == DT_ON)),
    .dtime_out    (dtime_out),
    .logic_out    (logic_out),
    .dt_onoff_out (dt_onoff_out)
  );
endmodule

// File: tb/tb_dtcfg_scheduler.sv
// Directed self-checking bench for dtcfg_scheduler (8 channels, 4-bit channel index).
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

module tb_dtcfg_scheduler;
  import PKG_pwm::*;

  localparam int unsigned N_CH = 8;
  localparam int unsigned CH_W = 4;
`ifdef DTCFG_SYNC_TIMEOUT_EN
  localparam int unsigned MAX_SYNC = 2;
`else
  localparam int unsigned MAX_SYNC = 4;
`endif

  logic                           clk, reset, sync_tick, fault, fault_clr;
  logic [N_CH-1:0]                pwmin;
  logic [N_CH*`DTCOUNT_WIDTH-1:0] dtime_out;
  logic [N_CH-1:0]                logic_out, dt_onoff_out;
  _pwm_onoff                      pwm_onoff;
  logic                           busy, upd_done, upd_drop;

  dtcfg_scheduler_if #(.CH_W(CH_W)) cfg_if ();

  dtcfg_scheduler #(
    .N_CH     (N_CH),
    .CH_W     (CH_W),
    .MAX_SYNC (MAX_SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg          (cfg_if.slave),
    .sync_tick    (sync_tick),
    .pwmin        (pwmin),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .dtime_out    (dtime_out),
    .logic_out    (logic_out),
    .dt_onoff_out (dt_onoff_out),
    .pwm_onoff    (pwm_onoff),
    .busy         (busy),
    .upd_done     (upd_done),
    .upd_drop     (upd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [N_CH*`DTCOUNT_WIDTH-1:0] exp_dt;
  logic [N_CH-1:0]                exp_lg, exp_on;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input int unsigned ch, input int unsigned dt, input logic lg, input _dt_onoff on);
    cfg_if.cfg_req      = 1'b1;
    cfg_if.cfg_chan     = CH_W'(ch);
    cfg_if.cfg_dtime    = `DTCOUNT_WIDTH'(dt);
    cfg_if.cfg_logic    = lg;
    cfg_if.cfg_dt_onoff = on;
  endtask

  task automatic pulse_tick();
    sync_tick = 1'b1;
    step(1);
    sync_tick = 1'b0;
  endtask

  task automatic check_live(input string tag);
    check({tag, "_dtime"}, 64'(dtime_out), 64'(exp_dt));
    check({tag, "_logic"}, 64'(logic_out), 64'(exp_lg));
    check({tag, "_dton"},  64'(dt_onoff_out), 64'(exp_on));
  endtask

  task automatic reset_exp();
    exp_dt = '0;
    exp_lg = '1;
    exp_on = '1;
  endtask

  initial begin
    reset = 1'b1; sync_tick = 1'b0; fault = 1'b0; fault_clr = 1'b0; pwmin = '0;
    cfg_if.cfg_req = 1'b0; cfg_if.cfg_chan = '0; cfg_if.cfg_dtime = '0;
    cfg_if.cfg_logic = 1'b1; cfg_if.cfg_dt_onoff = DT_ON;
    reset_exp();

    // Reset values, then first clean sync tick turns PWM on
    step(2);
    check("rst_pwm", 64'(pwm_onoff), 64'(PWM_OFF));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(cfg_if.cfg_ack), 64'd0);
    check("rst_done", 64'(upd_done), 64'd0);
    check("rst_drop", 64'(upd_drop), 64'd0);
    check_live("rst");
    reset = 1'b0;
    step(1);
    check("off_wait_pwm", 64'(pwm_onoff), 64'(PWM_OFF));
    pulse_tick();
    check("on_pwm", 64'(pwm_onoff), 64'(PWM_ON));
    check("on_busy", 64'(busy), 64'd0);
    check_live("on");

    // Chan 2 update committed at a tick 10 cycles after the request
    request(2, 25, 1'b0, DT_OFF);
    step(1);
    check("c2_ack", 64'(cfg_if.cfg_ack), 64'd1);
    check("c2_busy", 64'(busy), 64'd1);
    cfg_if.cfg_req = 1'b0;
    step(1);
    check("c2_ack_pulse", 64'(cfg_if.cfg_ack), 64'd0);
    step(8);
    check_live("c2_hold");
    pulse_tick();
    check("c2_done_early", 64'(upd_done), 64'd0);
    step(1);
    exp_dt[2*8 +: 8] = 8'd25; exp_lg[2] = 1'b0; exp_on[2] = 1'b0;
    check("c2_done", 64'(upd_done), 64'd1);
    check("c2_busy_clr", 64'(busy), 64'd0);
    check_live("c2_commit");
    step(1);
    check("c2_done_pulse", 64'(upd_done), 64'd0);

    // Chan 5 with its PWM input high across several ticks
    pwmin[5] = 1'b1;
    request(5, 7, 1'b1, DT_ON);
    step(1);
    check("c5_ack", 64'(cfg_if.cfg_ack), 64'd1);
    cfg_if.cfg_req = 1'b0;
`ifdef DTCFG_SYNC_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      pulse_tick();
      check("c5_drop", 64'(upd_drop), (k == 1) ? 64'd1 : 64'd0);
      step(2);
    end
    check("c5_drop_busy", 64'(busy), 64'd0);
    check_live("c5_dropped");
    pwmin[5] = 1'b0;
`else
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      check("c5_wait_done", 64'(upd_done), 64'd0);
      check("c5_wait_drop", 64'(upd_drop), 64'd0);
      step(2);
    end
    check("c5_wait_busy", 64'(busy), 64'd1);
    check_live("c5_wait");
    pwmin[5] = 1'b0;
    pulse_tick();
    step(1);
    exp_dt[5*8 +: 8] = 8'd7;
    check("c5_done", 64'(upd_done), 64'd1);
    check_live("c5_commit");
`endif

    // Second request while busy stalls until the first commits
    request(1, 11, 1'b1, DT_ON);
    step(1);
    check("b1_ack", 64'(cfg_if.cfg_ack), 64'd1);
    request(3, 33, 1'b1, DT_ON);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("b3_stall_ack", 64'(cfg_if.cfg_ack), 64'd0);
    end
    pulse_tick();
    step(1);
    exp_dt[1*8 +: 8] = 8'd11;
    check("b1_done", 64'(upd_done), 64'd1);
    check("b3_no_ack_yet", 64'(cfg_if.cfg_ack), 64'd0);
    check_live("b1_commit");
    step(1);
    check("b3_ack", 64'(cfg_if.cfg_ack), 64'd1);
    check("b3_busy", 64'(busy), 64'd1);
    cfg_if.cfg_req = 1'b0;
    pulse_tick();
    step(1);
    exp_dt[3*8 +: 8] = 8'd33;
    check("b3_done", 64'(upd_done), 64'd1);
    check_live("b3_commit");

    // Tick coinciding with an accepted request is not used for the commit
    request(0, 5, 1'b1, DT_ON);
    sync_tick = 1'b1;
    step(1);
    sync_tick = 1'b0;
    cfg_if.cfg_req = 1'b0;
    check("s0_ack", 64'(cfg_if.cfg_ack), 64'd1);
    step(2);
    check("s0_no_done", 64'(upd_done), 64'd0);
    check("s0_busy", 64'(busy), 64'd1);
    pulse_tick();
    step(1);
    exp_dt[0*8 +: 8] = 8'd5;
    check("s0_done", 64'(upd_done), 64'd1);
    check_live("s0_commit");

    // Fault while pending discards the update and holds PWM off
    request(4, 44, 1'b1, DT_ON);
    step(1);
    check("f4_ack", 64'(cfg_if.cfg_ack), 64'd1);
    cfg_if.cfg_req = 1'b0;
    fault = 1'b1;
    step(1);
    check("f_pwm_off", 64'(pwm_onoff), 64'(PWM_OFF));
    check("f_busy", 64'(busy), 64'd0);
    pulse_tick();
    check("f_no_done", 64'(upd_done), 64'd0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    fault = 1'b0;
    step(1);
    pulse_tick();
    check("f_clr_ignored", 64'(pwm_onoff), 64'(PWM_OFF));
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("f_off_pwm", 64'(pwm_onoff), 64'(PWM_OFF));
    check_live("f_retained");
    pulse_tick();
    check("f_recover_pwm", 64'(pwm_onoff), 64'(PWM_ON));
    check("f_recover_done", 64'(upd_done), 64'd0);

    // Out-of-range channel is acknowledged and discarded
    request(9, 99, 1'b0, DT_OFF);
    step(1);
    check("c9_ack", 64'(cfg_if.cfg_ack), 64'd1);
    check("c9_busy", 64'(busy), 64'd0);
    cfg_if.cfg_req = 1'b0;
    step(1);
    check("c9_busy2", 64'(busy), 64'd0);
    check_live("c9_nochange");

    // Reset mid-update loses the shadow; while off, requests commit at once
    pwmin[2] = 1'b1;
    request(2, 77, 1'b1, DT_ON);
    step(1);
    check("r_busy", 64'(busy), 64'd1);
    cfg_if.cfg_req = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    reset_exp();
    check("r_pwm", 64'(pwm_onoff), 64'(PWM_OFF));
    check("r_busy_clr", 64'(busy), 64'd0);
    check_live("r_live");
    request(6, 66, 1'b0, DT_ON);
    step(1);
    exp_dt[6*8 +: 8] = 8'd66; exp_lg[6] = 1'b0;
    check("o6_ack", 64'(cfg_if.cfg_ack), 64'd1);
    check_live("o6_immediate");
    cfg_if.cfg_req = 1'b0;
    pwmin[2] = 1'b0;
    pulse_tick();
    check("o_pwm_on", 64'(pwm_onoff), 64'(PWM_ON));
    step(2);
    check("o_no_done", 64'(upd_done), 64'd0);
    check_live("o_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dtcfg_scheduler.md
Name: dtcfg_scheduler

Overview:
- Configuration controller for a bank of N deadtime_single channels.
- Accepts dead-time, polarity and enable updates from the register interface through a req/ack handshake.
- Holds each update in a shadow register and commits it to the live outputs only at a safe point: a carrier sync tick with that channel's PWM input low.
- Owns the global PWM enable. It forces PWM_OFF on an external fault until software clears the fault.

Parameters:
- N_CH, 8, number of dead-time channels served.
- CH_W, 3, width of the channel index; must satisfy 2**CH_W >= N_CH.
- MAX_SYNC, 4, number of sync ticks a pending update may wait before it is dropped (only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_req  in  1  update request; held until cfg_ack.
- cfg_chan  in  CH_W  target channel.
- cfg_dtime  in  `DTCOUNT_WIDTH  new dead-time count.
- cfg_logic  in  1  new output polarity.
- cfg_dt_onoff  in  _dt_onoff  new dead-time enable.
- cfg_ack  out  1  one-cycle pulse: request accepted into shadow.
- sync_tick  in  1  one-cycle carrier-sync pulse.
- pwmin  in  N_CH  raw PWM inputs of each channel.
- fault  in  1  level fault input.
- fault_clr  in  1  one-cycle clear pulse.
- dtime_out  out  N_CH*`DTCOUNT_WIDTH  live dead-time per channel.
- logic_out  out  N_CH  live polarity per channel.
- dt_onoff_out  out  N_CH  live dead-time enable per channel (1 = DT_ON).
- pwm_onoff  out  _pwm_onoff  global PWM enable.
- busy  out  1  an update is pending.
- upd_done  out  1  one-cycle pulse on commit.
- upd_drop  out  1  one-cycle pulse on timeout drop.

Behaviour:
- Reset values:
  - all dtime_out = 0, logic_out = all 1, dt_onoff_out = all DT_ON.
  - pwm_onoff = PWM_OFF; cfg_ack = busy = upd_done = upd_drop = 0.
  - FSM in S_OFF, shadow registers cleared, sync counter = 0.
- FSM states: S_OFF, S_IDLE, S_PEND, S_APPLY, S_FAULT.
- S_OFF:
  - After reset, waits for the first sync_tick with fault = 0, then goes to S_IDLE and pwm_onoff = PWM_ON.
  - Requests are accepted in this state and committed immediately; no output is switching.
- S_IDLE:
  - On cfg_req with cfg_chan < N_CH: latch the fields into the shadow, pulse cfg_ack in the next cycle, go to S_PEND, busy = 1.
  - On cfg_req with cfg_chan >= N_CH: ack, discard, stay in S_IDLE.
- S_PEND:
  - On sync_tick with pwmin[shadow_chan] = 0, go to S_APPLY.
  - On sync_tick with pwmin = 1, increment the sync counter and stay.
  - New cfg_req is not acked while pending; the requester stalls.
- S_APPLY (one cycle):
  - Write shadow values to the channel's live outputs; they are visible in the cycle after S_APPLY.
  - Pulse upd_done, clear busy and the sync counter, return to S_IDLE.
  - Commit latency from cfg_ack: >= 2 cycles; bounded by sync period × (pending syncs + 1).
- S_FAULT:
  - Entered from any state the cycle after fault = 1 is sampled; fault has priority over everything, including a simultaneous S_APPLY.
  - pwm_onoff = PWM_OFF and the pending update is discarded (busy = 0, no upd_done).
  - Live configuration is retained.
  - Exit to S_OFF on fault_clr while fault = 0; fault_clr while fault = 1 is ignored.
- Simultaneous events:
  - sync_tick and cfg_req in S_IDLE: the request is accepted; that tick is not used for commit.
  - Request for the same channel as the last commit: handled normally.
- Reset mid-operation returns everything to reset values; the pending shadow is lost.
- Sync counter is saturating, width clog2(MAX_SYNC + 1).

Optional Feature:
- Macro: DTCFG_SYNC_TIMEOUT_EN.
- Defined: in S_PEND, when the sync counter reaches MAX_SYNC at a sync_tick with pwmin still high, drop the update, pulse upd_drop, clear busy, return to S_IDLE.
- Undefined: S_PEND waits indefinitely; upd_drop is tied to 0 and the MAX_SYNC parameter is unused.

Decomposition:
- PKG_pwm: the state enum type _state_dtcfg; the reused _pwm_onoff/_dt_onoff types with PWM_ON/PWM_OFF, DT_ON/DT_OFF; `DTCOUNT_WIDTH.
- Natural sub-module: dtcfg_shadow_bank. It holds the per-channel live register array with a single write port (chan, data, we), keeping the FSM free of the array logic.

Test Plan:
- Reset, then sync_tick with fault = 0 -> pwm_onoff = PWM_ON, all dtime_out = 0, busy = 0.
- In S_IDLE: req chan 2, dtime 25, pwmin[2] = 0, sync_tick 10 cycles later -> cfg_ack next cycle; dtime_out[2] = 25 and upd_done one cycle after the tick; other channels unchanged.
- Req chan 5 with pwmin[5] = 1 for 3 ticks, then 0 at the 4th -> commit on the 4th tick. With DTCFG_SYNC_TIMEOUT_EN and MAX_SYNC = 2: upd_drop at the 2nd tick, dtime_out[5] unchanged.
- Second req while busy -> no cfg_ack until upd_done; then acked and committed at a following tick.
- fault = 1 while S_PEND -> next cycle pwm_onoff = PWM_OFF, busy = 0, no upd_done. fault_clr while fault = 1 -> stays in S_FAULT. fault = 0 then fault_clr, then sync_tick -> PWM_ON.
- Req chan 9 with N_CH = 8 -> cfg_ack pulses, no output change, busy stays 0.
